// File: rtl/pit_bus_master.sv
// +--------------------------------------------------------------------------+
// | pit_bus_master                                                           |
// | Sequences host commands into timed 8254 PIT CPU bus cycles.              |
// | Optional: define PIT_READBACK_EN to turn op 10 / rw 00 into status read. |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module pit_bus_master #(
  parameter int SETUP_CYC  = 1,
  parameter int STROBE_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [1:0]  cmd_sel,
  input  logic [1:0]  cmd_rw,
  input  logic [15:0] cmd_data,
  output logic        rsp_valid,
  output logic        rsp_err,
  output logic [15:0] rsp_data,
  output logic        CS,
  output logic        WR,
  output logic        RD,
  output logic        A0,
  output logic        A1,
  output logic [7:0]  data_out,
  output logic        data_oe,
  input  logic [7:0]  data_in
);

  localparam logic [7:0] C_SETUP_LD  = 8'(SETUP_CYC - 1);
  localparam logic [7:0] C_STROBE_LD = 8'(STROBE_CYC - 1);
  localparam logic [7:0] C_HOLD_LD   = 8'(HOLD_CYC - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_GAP, ST_DONE
  } state_t;

  state_t      r_state;
  logic [7:0]  r_cnt;
  logic [1:0]  r_idx;
  logic [1:0]  r_nb;
  logic [2:0]  r_bw;   // per byte: 1 = write, 0 = read
  logic [2:0]  r_bm;   // per byte: read lands in rsp_data[15:8]
  logic [5:0]  r_ba;
  logic [23:0] r_bd;
  logic        r_hasread;
  logic [15:0] r_acc;

  logic [1:0]  w_nb;
  logic [2:0]  w_bw;
  logic [2:0]  w_bm;
  logic [5:0]  w_ba;
  logic [23:0] w_bd;
  logic        w_illegal;
  logic [1:0]  w_idx_next;

  // Byte plan for the offered command; an empty plan means rw=00 was illegal.
  always_comb begin
    w_nb = 2'd0;
    w_bw = 3'b000;
    w_bm = 3'b000;
    w_ba = 6'd0;
    w_bd = 24'd0;
    case (cmd_op)
      2'b00: begin
        w_nb      = 2'd1;
        w_bw      = 3'b001;
        w_ba[1:0] = 2'b11;
        w_bd[7:0] = cmd_data[7:0];
      end
      2'b01: begin
        w_bw = 3'b011;
        w_ba = {2'b00, cmd_sel, cmd_sel};
        case (cmd_rw)
          2'b11: begin w_nb = 2'd2; w_bd = {8'h00, cmd_data[15:8], cmd_data[7:0]}; end
          2'b01: begin w_nb = 2'd1; w_bd[7:0] = cmd_data[7:0]; end
          2'b10: begin w_nb = 2'd1; w_bd[7:0] = cmd_data[15:8]; end
          default: w_nb = 2'd0;
        endcase
      end
      2'b10: begin
        w_ba = {2'b00, cmd_sel, cmd_sel};
        case (cmd_rw)
          2'b11: begin w_nb = 2'd2; w_bm = 3'b010; end
          2'b01: w_nb = 2'd1;
          2'b10: begin w_nb = 2'd1; w_bm = 3'b001; end
          default: begin
`ifdef PIT_READBACK_EN
            w_nb      = 2'd2;
            w_bw      = 3'b001;
            w_ba      = {2'b00, cmd_sel, 2'b11};
            w_bd[7:0] = 8'hD0 | 8'(8'h02 << cmd_sel);
`else
            w_nb = 2'd0;
`endif
          end
        endcase
      end
      default: begin
        w_bw      = 3'b001;
        w_ba      = {cmd_sel, cmd_sel, 2'b11};
        w_bd[7:0] = {cmd_sel, 6'b000000};
        case (cmd_rw)
          2'b11: begin w_nb = 2'd3; w_bm = 3'b100; end
          2'b01: w_nb = 2'd2;
          2'b10: begin w_nb = 2'd2; w_bm = 3'b010; end
          default: w_nb = 2'd0;
        endcase
      end
    endcase
    w_illegal = (cmd_op != 2'b00) && ((cmd_sel == 2'b11) || (w_nb == 2'd0));
  end

  assign w_idx_next = r_idx + 2'd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_cnt     <= 8'd0;
      r_idx     <= 2'd0;
      r_nb      <= 2'd0;
      r_bw      <= 3'b000;
      r_bm      <= 3'b000;
      r_ba      <= 6'd0;
      r_bd      <= 24'd0;
      r_hasread <= 1'b0;
      r_acc     <= 16'd0;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_data  <= 16'd0;
      CS        <= 1'b1;
      WR        <= 1'b1;
      RD        <= 1'b1;
      A0        <= 1'b0;
      A1        <= 1'b0;
      data_out  <= 8'd0;
      data_oe   <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_ready <= 1'b0;
            r_nb      <= w_nb;
            r_bw      <= w_bw;
            r_bm      <= w_bm;
            r_ba      <= w_ba;
            r_bd      <= w_bd;
            r_hasread <= cmd_op[1];
            r_acc     <= 16'd0;
            r_idx     <= 2'd0;
            if (w_illegal) begin
              r_state   <= ST_DONE;
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              r_hasread <= 1'b0;
            end else begin
              r_state  <= ST_SETUP;
              r_cnt    <= C_SETUP_LD;
              CS       <= 1'b0;
              {A1, A0} <= w_ba[1:0];
              data_out <= w_bd[7:0];
              data_oe  <= w_bw[0];
            end
          end
        end
        ST_SETUP: begin
          if (r_cnt == 8'd0) begin
            r_state <= ST_STROBE;
            r_cnt   <= C_STROBE_LD;
            WR      <= ~r_bw[r_idx];
            RD      <= r_bw[r_idx];
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_STROBE: begin
          if (r_cnt == 8'd0) begin
            // Sample read data in the final strobe cycle, just before RD rises.
            if (!r_bw[r_idx]) begin
              if (r_bm[r_idx]) r_acc[15:8] <= data_in;
              else             r_acc[7:0]  <= data_in;
            end
            r_state <= ST_HOLD;
            r_cnt   <= C_HOLD_LD;
            WR      <= 1'b1;
            RD      <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_HOLD: begin
          if (r_cnt == 8'd0) begin
            CS      <= 1'b1;
            data_oe <= 1'b0;
            if (w_idx_next < r_nb) begin
              r_state <= ST_GAP;
              r_idx   <= w_idx_next;
            end else begin
              r_state   <= ST_DONE;
              rsp_valid <= 1'b1;
              if (r_hasread) rsp_data <= r_acc;
            end
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        ST_GAP: begin
          r_state  <= ST_SETUP;
          r_cnt    <= C_SETUP_LD;
          CS       <= 1'b0;
          {A1, A0} <= r_ba[{r_idx, 1'b0} +: 2];
          data_out <= r_bd[{r_idx, 3'b000} +: 8];
          data_oe  <= r_bw[r_idx];
        end
        default: begin
          r_state   <= ST_IDLE;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_pit_bus_master.sv
// +--------------------------------------------------------------------------+
// | tb_pit_bus_master                                                        |
// | Scoreboard bench: queued responses/bus cycles checked by monitors.       |
// | Revision: 1.0 - initial release                                          |
// +--------------------------------------------------------------------------+
`default_nettype none
`timescale 1ns/1ps

module tb_pit_bus_master;

  localparam int SETUP  = 1;
  localparam int STROBE = 2;
  localparam int HOLD   = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [1:0]  cmd_op, cmd_sel, cmd_rw;
  logic [15:0] cmd_data;
  logic        rsp_valid, rsp_err;
  logic [15:0] rsp_data;
  logic        CS, WR, RD, A0, A1;
  logic [7:0]  data_out;
  logic        data_oe;
  logic [7:0]  data_in = 8'h00;

  pit_bus_master #(.SETUP_CYC(SETUP), .STROBE_CYC(STROBE), .HOLD_CYC(HOLD)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_sel(cmd_sel), .cmd_rw(cmd_rw), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_data(rsp_data),
    .CS(CS), .WR(WR), .RD(RD), .A0(A0), .A1(A1),
    .data_out(data_out), .data_oe(data_oe), .data_in(data_in)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          err;
    logic [15:0] data;
    int          lat;
    int          acc;
  } rsp_t;

  typedef struct {
    bit         w;
    logic [1:0] a;
    logic [7:0] d;
  } bus_t;

  rsp_t       rspq[$];
  bus_t       busq[$];
  logic [7:0] rdq[$];

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag(input string name);
    checks++;
    errors++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  // Response monitor
  always @(negedge clk) begin
    rsp_t e;
    if (!reset && rsp_valid) begin
      if (rspq.size() == 0) flag("rsp_unexpected");
      else begin
        e = rspq.pop_front();
        chk("rsp_err", rsp_err, e.err);
        chk("rsp_data", rsp_data, e.data);
        chk("rsp_latency", cyc - e.acc, e.lat);
        chk("ready_in_done", cmd_ready, 0);
      end
    end
  end

  // Bus monitor: frames each CS-low period and also plays the 8254 read side
  bit         in_cyc = 0;
  int         pre, stb, post;
  bit         wr_seen, rd_seen, oe_all, oe_any, unstable;
  logic [1:0] a_s;
  logic [7:0] d_s;

  always @(negedge clk) begin
    bus_t b;
    if (reset) in_cyc = 0;
    else if (!CS) begin
      if (!in_cyc) begin
        in_cyc = 1; pre = 0; stb = 0; post = 0;
        wr_seen = 0; rd_seen = 0; oe_all = 1; oe_any = 0; unstable = 0;
        a_s = {A1, A0}; d_s = data_out;
      end
      if ({A1, A0} !== a_s || data_out !== d_s) unstable = 1;
      oe_all &= data_oe;
      oe_any |= data_oe;
      if (!WR || !RD) begin
        stb++;
        if (!WR) wr_seen = 1;
        if (!RD) rd_seen = 1;
      end else if (stb == 0) pre++;
      else post++;
      if (!RD && rdq.size() > 0) data_in = rdq[0];
    end else if (in_cyc) begin
      in_cyc = 0;
      if (busq.size() == 0) flag("bus_unexpected");
      else begin
        b = busq.pop_front();
        chk("bus_wr", wr_seen, b.w);
        chk("bus_rd", rd_seen, !b.w);
        chk("bus_addr", a_s, b.a);
        if (b.w) chk("bus_data", d_s, b.d);
        chk("bus_oe", b.w ? oe_all : oe_any, b.w);
        chk("bus_setup", pre, SETUP);
        chk("bus_strobe", stb, STROBE);
        chk("bus_hold", post, HOLD);
        chk("bus_stable", unstable, 0);
        if (!b.w && rdq.size() > 0) void'(rdq.pop_front());
      end
    end
  end

  task automatic push_w(input logic [1:0] a, input logic [7:0] d);
    bus_t b;
    b.w = 1; b.a = a; b.d = d;
    busq.push_back(b);
  endtask

  task automatic push_r(input logic [1:0] a, input logic [7:0] d);
    bus_t b;
    b.w = 0; b.a = a; b.d = 8'h00;
    busq.push_back(b);
    rdq.push_back(d);
  endtask

  task automatic send(input logic [1:0] op, input logic [1:0] sel, input logic [1:0] rw,
                      input logic [15:0] d, input bit err, input logic [15:0] rdat, input int lat);
    rsp_t e;
    int   n;
    @(negedge clk);
    cmd_op = op; cmd_sel = sel; cmd_rw = rw; cmd_data = d; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) flag("accept_timeout");
    else begin
      e.err = err; e.data = rdat; e.lat = lat; e.acc = cyc;
      rspq.push_back(e);
    end
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (rspq.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (rspq.size() != 0) begin
      flag("response_timeout");
      rspq.delete();
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_sel = 2'b00;
    cmd_rw = 2'b00; cmd_data = 16'h0000;
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_cs", CS, 1);
    chk("rst_wr", WR, 1);
    chk("rst_rd", RD, 1);
    chk("rst_addr", {A1, A0}, 0);
    chk("rst_data_out", data_out, 0);
    chk("rst_data_oe", data_oe, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_err", rsp_err, 0);
    chk("rst_rsp_data", rsp_data, 0);

    // Control word write
    push_w(2'b11, 8'h52);
    send(2'b00, 2'b00, 2'b00, 16'h0052, 0, 16'h0000, 5);
    // Two-byte counter load on counter 2
    push_w(2'b10, 8'h34); push_w(2'b10, 8'h12);
    send(2'b01, 2'b10, 2'b11, 16'h1234, 0, 16'h0000, 10);
    // Latch + read counter 1
    push_w(2'b11, 8'h40); push_r(2'b01, 8'hCD); push_r(2'b01, 8'hAB);
    send(2'b11, 2'b01, 2'b11, 16'h0000, 0, 16'hABCD, 15);
    // LSB-only and MSB-only reads
    push_r(2'b00, 8'h5A);
    send(2'b10, 2'b00, 2'b01, 16'h0000, 0, 16'h005A, 5);
    push_r(2'b10, 8'h77);
    send(2'b10, 2'b10, 2'b10, 16'h0000, 0, 16'h7700, 5);
    // MSB-only write leaves rsp_data alone
    push_w(2'b00, 8'hBE);
    send(2'b01, 2'b00, 2'b10, 16'hBEEF, 0, 16'h7700, 5);
    // Illegal: counter select 3
    send(2'b01, 2'b11, 2'b11, 16'h1111, 1, 16'h7700, 1);
`ifdef PIT_READBACK_EN
    push_w(2'b11, 8'hD2); push_r(2'b00, 8'h36);
    send(2'b10, 2'b00, 2'b00, 16'h0000, 0, 16'h0036, 10);
    // Latch+read with rw=00 remains illegal
    send(2'b11, 2'b10, 2'b00, 16'h0000, 1, 16'h0036, 1);
    push_w(2'b11, 8'hFF);
    send(2'b00, 2'b11, 2'b00, 16'h01FF, 0, 16'h0036, 5);
`else
    send(2'b10, 2'b00, 2'b00, 16'h0000, 1, 16'h7700, 1);
    send(2'b11, 2'b10, 2'b00, 16'h0000, 1, 16'h7700, 1);
    // Control write ignores sel, even sel=3
    push_w(2'b11, 8'hFF);
    send(2'b00, 2'b11, 2'b00, 16'h01FF, 0, 16'h7700, 5);
`endif
    wait_idle();

    // Abort a write with reset during its strobe
    @(negedge clk);
    cmd_op = 2'b01; cmd_sel = 2'b00; cmd_rw = 2'b11; cmd_data = 16'h1111; cmd_valid = 1'b1;
    @(posedge clk);
    #1 cmd_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (WR && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (WR) flag("wr_strobe_timeout");
    reset = 1'b1;
    @(negedge clk);
    chk("abort_wr", WR, 1);
    chk("abort_cs", CS, 1);
    chk("abort_oe", data_oe, 0);
    chk("abort_ready", cmd_ready, 1);
    chk("abort_rsp_valid", rsp_valid, 0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_rsp_data", rsp_data, 0);

    // Recovery after the abort
    push_w(2'b11, 8'hA5);
    send(2'b00, 2'b00, 2'b00, 16'h00A5, 0, 16'h0000, 5);
    wait_idle();
    repeat (6) @(negedge clk);
    chk("rspq_drained", rspq.size(), 0);
    chk("busq_drained", busq.size(), 0);
    chk("rdq_drained", rdq.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/pit_bus_master.md
Name: pit_bus_master

Overview:
- Host-side bus controller that drives the 8254 PIT CPU interface: chip select, write and read strobes, address lines A1/A0, and the 8-bit data bus.
- Converts single-cycle commands (control-word write, counter load, counter read, latch-and-read) into correctly timed 8254 bus cycles.
- Handles LSB/MSB byte sequencing and returns read data and a completion response.
- Sits between the system command fabric and intel8254.

Parameters:
- SETUP_CYC, 1: cycles address/data/cs are driven before the strobe falls (>=1).
- STROBE_CYC, 2: cycles wr or rd is held low (>=1).
- HOLD_CYC, 1: cycles address/data/cs are held after the strobe rises (>=1).

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- cmd_valid  input  1  command request
- cmd_ready  output  1  high in IDLE only; accept on cmd_valid&cmd_ready
- cmd_op  input  2  00 ctrl write, 01 counter write, 10 counter read, 11 latch+read
- cmd_sel  input  2  counter 0..2; 3 is illegal for ops 01/10/11
- cmd_rw  input  2  01 LSB only, 10 MSB only, 11 LSB then MSB
- cmd_data  input  16  write value; ctrl write uses [7:0]
- rsp_valid  output  1  one-cycle completion pulse
- rsp_err  output  1  qualifies rsp_valid; illegal command
- rsp_data  output  16  read result, valid with rsp_valid
- CS  output  1  active-low chip select
- WR  output  1  active-low write strobe
- RD  output  1  active-low read strobe
- A0  output  1  address bit 0
- A1  output  1  address bit 1
- data_out  output  8  bus write data
- data_oe  output  1  data_out drive enable
- data_in  input  8  bus read data

Behaviour:
- Reset values:
  - CS=WR=RD=1, A0=A1=0, data_out=0, data_oe=0.
  - rsp_valid=0, rsp_err=0, rsp_data=0.
  - State IDLE, so cmd_ready=1.
- Reset mid-transfer: state returns to IDLE at the next edge and all strobes go inactive. No response is issued for the aborted command.
- FSM states: IDLE, SETUP, STROBE, HOLD, GAP, DONE. A per-state counter counts down the parameter value for SETUP, STROBE and HOLD.
- Accept (IDLE):
  - Command fields are registered on acceptance.
  - An illegal command goes straight to DONE with rsp_err=1 and no bus activity. Illegal means: sel=3 with op!=00, or rw=00 with op 01/10/11 (see Optional Feature).
- Bus-cycle sequence per byte:
  - SETUP: CS=0, address and data_oe valid.
  - STROBE: WR=0 for writes, RD=0 for reads.
  - HOLD: strobe returns to 1; CS, address and data unchanged.
  - After HOLD: if another byte is pending, go to GAP, else DONE.
  - GAP: one cycle with CS=WR=RD=1, data_oe=0; then SETUP for the next byte.
- Addressing:
  - Counter n uses {A1,A0}=n.
  - Control word uses {A1,A0}=11.
  - data_oe=1 throughout SETUP/STROBE/HOLD for write bytes, 0 for read bytes.
- Op 00: one byte, cmd_data[7:0] to address 11.
- Op 01:
  - rw=11: cmd_data[7:0] then cmd_data[15:8].
  - rw=01: [7:0] only.
  - rw=10: [15:8] only.
- Op 10: reads data_in in the last STROBE cycle.
  - LSB goes to rsp_data[7:0]; MSB goes to rsp_data[15:8].
  - Bytes not read return 0.
- Op 11:
  - First writes the latch command {sel,6'b000000} to address 11.
  - Then GAP, then the op 10 sequence.
- Latency with defaults: 4 cycles per byte.
  - Single-byte command: rsp_valid in the 5th cycle after acceptance.
  - Two-byte command: rsp_valid in the 10th cycle.
  - Latch+read with rw=11: rsp_valid in the 15th cycle.
- DONE: one cycle, rsp_valid=1, cmd_ready=0; then IDLE. rsp_data holds its value until the next read completes.
- rsp_valid pulses for writes too, with rsp_data unchanged.
- No backpressure on responses.

Optional Feature:
- Macro: PIT_READBACK_EN.
- When defined: op 10 with rw=00 is a status read.
  - Writes read-back command 8'b1101_0000 | (1<<(sel+1)) to address 11.
  - Then GAP, then one read byte, returned in rsp_data[7:0] with [15:8]=0.
- When undefined: op 10 with rw=00 is illegal (rsp_err=1, no bus activity).

Test Plan:
- Reset then idle → CS=WR=RD=1, data_oe=0, cmd_ready=1, rsp_valid=0.
- op=00, data=0x52 → address 11, data_out=0x52, WR low exactly 2 cycles framed by 1 setup and 1 hold cycle; rsp_valid in cycle 5, rsp_err=0.
- op=01, sel=2, rw=11, data=0x1234 → byte 0x34 then 0x12 to address 10, one GAP cycle with CS=1 between them; rsp_valid in cycle 10.
- op=11, sel=1, rw=11, data_in 0xCD then 0xAB → latch write 0x40 to address 11, then two RD pulses at address 01; rsp_data=0xABCD in cycle 15.
- op=01, sel=3 → rsp_valid and rsp_err=1 in cycle 1 after accept, CS never low. Then assert reset during STROBE of a write → next cycle WR=CS=1, cmd_ready=1, no rsp_valid.
- PIT_READBACK_EN: op=10, sel=0, rw=00, data_in=0x36 → write 0xD2 to address 11, then read; rsp_data=0x0036. Without the macro → rsp_err=1.
